// File: rtl/mole_game_pkg.sv
// Shared types, widths and the response-window helper for the whack-a-mole controller.
package mole_game_pkg;

    localparam int unsigned TIME_W  = 16;
    localparam int unsigned LVL_W   = 3;
    localparam int unsigned LIVES_W = 3;

    localparam logic [LVL_W-1:0] MAX_LEVEL = 3'd7;

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StPause,
        StOver
    } game_state_e;

    // Response window for a level; any underflow below the floor clamps to the floor.
    function automatic logic [TIME_W-1:0] calc_window(input logic [LVL_W-1:0] lvl,
                                                      input int unsigned  t_init,
                                                      input int unsigned  t_step,
                                                      input int unsigned  t_min);
        int unsigned dec;
        dec = 32'(lvl) * t_step;
        if (dec >= t_init || (t_init - dec) < t_min) begin
            return TIME_W'(t_min);
        end
        return TIME_W'(t_init - dec);
    endfunction

endpackage

// File: rtl/mole_game_controller_if.sv
// Event inputs and display/status outputs of the game controller.
interface mole_game_controller_if;
    import mole_game_pkg::*;

    logic               start;
    logic               pause;
    logic               guess_correct;
    logic               guess_wrong;
    logic               playing;
    logic               paused;
    logic               game_over;
    logic               mole_timeout;
    logic [LIVES_W-1:0] lives;
    logic [LVL_W-1:0]   level;
    logic [TIME_W-1:0]  time_left;

    modport slave (
        input  start, pause, guess_correct, guess_wrong,
        output playing, paused, game_over, mole_timeout, lives, level, time_left
    );

    modport master (
        output start, pause, guess_correct, guess_wrong,
        input  playing, paused, game_over, mole_timeout, lives, level, time_left
    );

endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler: counts while enabled, one-cycle tick at terminal count.
module ms_tick_gen #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned     CntW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_o = 1'b0;
        if (en_i) begin
            if (cnt_q == CntMax) begin
                tick_o = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
        // Clear wins so a reload always starts a full millisecond.
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mole_game_controller.sv
// Game-session FSM: per-mole response timer, lives and level tracking, timeout pulse.
module mole_game_controller
    import mole_game_pkg::*;
#(
    parameter int unsigned TICK_DIV       = 100000,
    parameter int unsigned MOLE_TIME_INIT = 1500,
    parameter int unsigned MOLE_TIME_STEP = 100,
    parameter int unsigned MOLE_TIME_MIN  = 400,
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned HITS_PER_LEVEL = 5
) (
    input logic                   clk,
    input logic                   rst_n,
    mole_game_controller_if.slave bus
);

    localparam int unsigned        HitW      = $clog2(HITS_PER_LEVEL + 1);
    localparam logic [HitW-1:0]    HitsMax   = HitW'(HITS_PER_LEVEL);
    localparam logic [LIVES_W-1:0] LivesInit = LIVES_W'(LIVES_INIT);

    game_state_e        state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [TIME_W-1:0]  time_q, time_d;
    logic [HitW-1:0]    hits_q, hits_d;
    logic               timeout_q, timeout_d;
    logic               playing_q, paused_q, over_q;
    logic               tick, presc_en, presc_clr;
    logic               lose_life, reload;

    assign presc_en = (state_q == StPlay);

    ms_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (presc_en),
        .clr_i (presc_clr),
        .tick_o(tick)
    );

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        level_d   = level_q;
        time_d    = time_q;
        hits_d    = hits_q;
        timeout_d = 1'b0;
        presc_clr = 1'b0;
        lose_life = 1'b0;
        reload    = 1'b0;

        unique case (state_q)
            StIdle, StOver: begin
                if (bus.start) begin
                    state_d   = StPlay;
                    lives_d   = LivesInit;
                    level_d   = '0;
                    hits_d    = '0;
                    time_d    = calc_window(LVL_W'(0), MOLE_TIME_INIT, MOLE_TIME_STEP,
                                            MOLE_TIME_MIN);
                    presc_clr = 1'b1;
                end
            end
            StPlay: begin
                if (bus.guess_correct) begin
                    reload = 1'b1;
                    if (hits_q + HitW'(1) == HitsMax) begin
                        hits_d = '0;
                        if (level_q != MAX_LEVEL) begin
                            level_d = level_q + LVL_W'(1);
                        end
                    end else begin
                        hits_d = hits_q + HitW'(1);
                    end
                end else if (bus.guess_wrong) begin
                    lose_life = 1'b1;
                end else if (tick) begin
                    if (time_q == TIME_W'(1)) begin
                        timeout_d = 1'b1;
                        time_d    = '0;
                        lose_life = 1'b1;
                    end else begin
                        time_d = time_q - TIME_W'(1);
                    end
                end

                // Last life lost: freeze the display values instead of reloading.
                if (lose_life) begin
                    if (lives_q <= LIVES_W'(1)) begin
                        lives_d = '0;
                        state_d = StOver;
                    end else begin
                        lives_d = lives_q - LIVES_W'(1);
                        reload  = 1'b1;
                    end
                end

                if (reload) begin
                    time_d    = calc_window(level_d, MOLE_TIME_INIT, MOLE_TIME_STEP,
                                            MOLE_TIME_MIN);
                    presc_clr = 1'b1;
                end

                if (bus.pause && state_d == StPlay) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (bus.start) begin
                    state_d = StIdle;
                end else if (bus.pause) begin
                    state_d = StPlay;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            lives_q   <= '0;
            level_q   <= '0;
            time_q    <= '0;
            hits_q    <= '0;
            timeout_q <= 1'b0;
            playing_q <= 1'b0;
            paused_q  <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lives_q   <= lives_d;
            level_q   <= level_d;
            time_q    <= time_d;
            hits_q    <= hits_d;
            timeout_q <= timeout_d;
            playing_q <= (state_d == StPlay);
            paused_q  <= (state_d == StPause);
            over_q    <= (state_d == StOver);
        end
    end

    assign bus.playing      = playing_q;
    assign bus.paused       = paused_q;
    assign bus.game_over    = over_q;
    assign bus.mole_timeout = timeout_q;
    assign bus.lives        = lives_q;
    assign bus.level        = level_q;
    assign bus.time_left    = time_q;

endmodule

// File: tb/tb_mole_game_controller.sv
// Directed and randomized checks of mole_game_controller against a behavioural game model.
module tb_mole_game_controller;

    localparam int TDIV  = 4;
    localparam int TINIT = 10;
    localparam int TSTEP = 3;
    localparam int TMIN  = 4;
    localparam int LIVES = 3;
    localparam int HITS  = 2;

    localparam int MIdle  = 0;
    localparam int MPlay  = 1;
    localparam int MPause = 2;
    localparam int MOver  = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model of the game as the player sees it.
    int m_mode, m_lives, m_level, m_time, m_hits, m_phase, m_timeout;

    mole_game_controller_if bus ();

    mole_game_controller #(
        .TICK_DIV      (TDIV),
        .MOLE_TIME_INIT(TINIT),
        .MOLE_TIME_STEP(TSTEP),
        .MOLE_TIME_MIN (TMIN),
        .LIVES_INIT    (LIVES),
        .HITS_PER_LEVEL(HITS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic int window(input int lvl);
        int w;
        w = TINIT - lvl * TSTEP;
        return (w < TMIN) ? TMIN : w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = MIdle; m_lives = 0; m_level = 0; m_time = 0;
        m_hits = 0; m_phase = 0; m_timeout = 0;
    endtask

    task automatic model_reload();
        m_time  = window(m_level);
        m_phase = 0;
    endtask

    task automatic model_update(input bit s, input bit p, input bit gc, input bit gw);
        bit tick, lost;
        m_timeout = 0;
        lost = 0;
        case (m_mode)
            MIdle, MOver: if (s) begin
                m_mode = MPlay; m_lives = LIVES; m_level = 0; m_hits = 0;
                model_reload();
            end
            MPlay: begin
                tick    = (m_phase == TDIV - 1);
                m_phase = tick ? 0 : m_phase + 1;
                if (gc) begin
                    m_hits++;
                    if (m_hits == HITS) begin
                        m_hits = 0;
                        if (m_level < 7) m_level++;
                    end
                    model_reload();
                end else if (gw) begin
                    lost = 1;
                end else if (tick) begin
                    m_time--;
                    if (m_time == 0) begin
                        m_timeout = 1;
                        lost = 1;
                    end
                end
                if (lost) begin
                    m_lives--;
                    if (m_lives == 0) m_mode = MOver;
                    else model_reload();
                end
                if (p && m_mode == MPlay) m_mode = MPause;
            end
            MPause: begin
                if (s) m_mode = MIdle;
                else if (p) m_mode = MPlay;
            end
            default: m_mode = MIdle;
        endcase
    endtask

    task automatic check_all();
        chk("playing", bus.playing, m_mode == MPlay);
        chk("paused", bus.paused, m_mode == MPause);
        chk("game_over", bus.game_over, m_mode == MOver);
        chk("mole_timeout", bus.mole_timeout, m_timeout);
        if (m_mode == MPlay || m_mode == MPause || m_mode == MOver) begin
            chk("lives", bus.lives, m_lives);
            chk("level", bus.level, m_level);
        end
        if (m_mode == MPlay || m_mode == MPause) begin
            chk("time_left", bus.time_left, m_time);
        end
    endtask

    task automatic step(input bit s, input bit p, input bit gc, input bit gw);
        bus.start = s; bus.pause = p; bus.guess_correct = gc; bus.guess_wrong = gw;
        @(posedge clk);
        model_update(s, p, gc, gw);
        #1;
        bus.start = 0; bus.pause = 0; bus.guess_correct = 0; bus.guess_wrong = 0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_playing"}, bus.playing, 0);
        chk({tag, "_paused"}, bus.paused, 0);
        chk({tag, "_over"}, bus.game_over, 0);
        chk({tag, "_timeout"}, bus.mole_timeout, 0);
        chk({tag, "_lives"}, bus.lives, 0);
        chk({tag, "_level"}, bus.level, 0);
        chk({tag, "_time"}, bus.time_left, 0);
    endtask

    initial begin
        int pulses;
        int guard;
        rst_n = 1'b0;
        bus.start = 0; bus.pause = 0; bus.guess_correct = 0; bus.guess_wrong = 0;
        model_reset();
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // 1: start, then first millisecond tick after TDIV cycles
        step(1, 0, 0, 0);
        chk("t1_playing", bus.playing, 1);
        chk("t1_lives", bus.lives, 3);
        chk("t1_time", bus.time_left, 10);
        idle(4);
        chk("t1_time_after_tick", bus.time_left, 9);

        // 2: three unanswered windows end the game
        pulses = 0;
        for (int i = 0; i < 36; i++) begin
            step(0, 0, 0, 0);
            pulses += int'(bus.mole_timeout);
        end
        chk("t2_pulses", pulses, 1);
        chk("t2_lives", bus.lives, 2);
        chk("t2_time", bus.time_left, 10);
        for (int i = 0; i < 80; i++) begin
            step(0, 0, 0, 0);
            pulses += int'(bus.mole_timeout);
        end
        chk("t2_pulses_total", pulses, 3);
        chk("t2_over", bus.game_over, 1);
        chk("t2_lives_over", bus.lives, 0);
        chk("t2_playing_over", bus.playing, 0);

        // 3: level progression and window floor (also restart from OVER)
        step(1, 0, 0, 0);
        chk("t6_restart_lives", bus.lives, 3);
        chk("t6_restart_level", bus.level, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("t3_level1", bus.level, 1);
        chk("t3_time1", bus.time_left, 7);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("t3_level2", bus.level, 2);
        chk("t3_time2", bus.time_left, 4);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("t3_level3", bus.level, 3);
        chk("t3_time3", bus.time_left, 4);

        // 4: guess_correct masks guess_wrong and an expiring tick
        idle(5);
        step(0, 0, 1, 1);
        chk("t4_lives_both", bus.lives, 3);
        chk("t4_time_both", bus.time_left, 4);
        guard = 0;
        while ((m_time != 1 || m_phase != TDIV - 1) && guard < 100) begin
            step(0, 0, 0, 0);
            guard++;
        end
        chk("t4_reach_expiry", guard < 100, 1);
        step(0, 0, 1, 0);
        chk("t4_no_timeout", bus.mole_timeout, 0);
        chk("t4_lives_exp", bus.lives, 3);
        chk("t4_time_exp", bus.time_left, 4);

        // 5: pause freezes everything, resume continues, start aborts from pause
        step(0, 1, 0, 0);
        chk("t5_paused", bus.paused, 1);
        step(1, 0, 0, 0);
        chk("t5_abort_idle", bus.playing | bus.paused | bus.game_over, 0);
        step(1, 0, 0, 0);
        idle(16);
        step(0, 1, 0, 0);
        chk("t5_pause_time", bus.time_left, 6);
        idle(100);
        step(0, 0, 0, 1);
        chk("t5_held_time", bus.time_left, 6);
        chk("t5_held_lives", bus.lives, 3);
        step(0, 1, 0, 0);
        chk("t5_resumed", bus.playing, 1);
        idle(2);
        chk("t5_resume_time", bus.time_left, 6);
        idle(1);
        chk("t5_resume_tick", bus.time_left, 5);

        // 6: asynchronous reset mid-play
        idle(3);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Random play against the model
        for (int i = 0; i < 600; i++) begin
            bit s, p, gc, gw;
            s  = ($urandom_range(99) < 3);
            p  = ($urandom_range(99) < 5);
            gc = ($urandom_range(99) < 8);
            gw = ($urandom_range(99) < 4);
            step(s, p, gc, gw);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mole_game_controller.md
Name: mole_game_controller

Overview:
Sequences one whack-a-mole game session: idle, play, pause and game-over.
Runs a per-mole response timer that shrinks as the level rises, and tracks lives and level.
Issues a timeout pulse that forces a new mole position when the player is too slow.
Sits between the score evaluation block (consumes its guess_correct/guess_wrong pulses) and mole positioning; its outputs also drive the LED display.

Parameters:
TICK_DIV, 100000, clk cycles per 1 ms tick (100 MHz clock)
MOLE_TIME_INIT, 1500, response window at level 0, in ms
MOLE_TIME_STEP, 100, window reduction per level, in ms
MOLE_TIME_MIN, 400, floor on the response window, in ms
LIVES_INIT, 3, lives at game start (1..7)
HITS_PER_LEVEL, 5, correct hits needed to advance one level

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; starts a game (debounced upstream)
pause  input  1  one-cycle pulse; toggles PLAY/PAUSE
guess_correct  input  1  one-cycle pulse from score evaluation
guess_wrong  input  1  one-cycle pulse from score evaluation
playing  output  1  high in PLAY
paused  output  1  high in PAUSE
game_over  output  1  high in OVER
mole_timeout  output  1  one-cycle pulse; request new mole position
lives  output  3  remaining lives
level  output  3  current level, saturates at 7
time_left  output  16  ms remaining in the current window

Behaviour:
- Clock/reset: single clk domain. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, playing=0, paused=0, game_over=0, mole_timeout=0, lives=0, level=0, time_left=0, hit count=0, prescaler=0.
- Prescaler: counts 0..TICK_DIV-1 and only while in PLAY. It emits tick for one cycle at terminal count. It clears on entry to PLAY and on every window reload.
- Window: window = max(MOLE_TIME_INIT - level*MOLE_TIME_STEP, MOLE_TIME_MIN), computed in 16 bits. Any underflow clamps to MOLE_TIME_MIN.
- IDLE:
  - start -> PLAY the next cycle.
  - On that transition, load lives=LIVES_INIT, level=0, hit count=0, time_left=window(0).
- PLAY, events are prioritised as follows:
  1. guess_correct:
     - hit count += 1 and reload time_left.
     - If hit count reaches HITS_PER_LEVEL: hit count clears and level increments (holds at 7). The reload then uses the new level's window.
  2. guess_wrong: lives -= 1 and reload time_left.
  3. tick while time_left==1:
     - time_left hits 0, so assert mole_timeout for exactly one cycle.
     - lives -= 1 and reload time_left.
  4. Plain tick: time_left -= 1.
  5. pause -> PAUSE.
- Priority rules:
  - guess_correct masks guess_wrong and an expiring tick in the same cycle.
  - guess_wrong masks an expiring tick.
  - pause in the same cycle as an event: the event is applied and the state still moves to PAUSE.
- Out of lives: any decrement from lives==1 goes to OVER with lives=0. mole_timeout still pulses if expiry caused it.
- PAUSE:
  - Timer and prescaler are frozen.
  - guess_correct and guess_wrong are ignored.
  - pause -> PLAY with time_left unchanged and prescaler resumed from its held value.
  - start -> IDLE (abort).
- OVER:
  - lives, level and time_left are held for display.
  - guess_correct and guess_wrong are ignored.
  - start -> PLAY with a full reload, same as from IDLE.
- start in PLAY is ignored.
- Outputs: playing, paused and game_over are registered state decodes; exactly one or none is high.
- Latency: event pulse to register update is 1 cycle.
- Reset mid-game: asynchronous return to reset values, with no timeout pulse emitted.

Decomposition:
- Package mole_game_pkg:
  - state enum: IDLE, PLAY, PAUSE, OVER (2-bit).
  - Widths: TIME_W=16, LVL_W=3, LIVES_W=3.
  - MAX_LEVEL=7.
- Sub-module ms_tick_gen (prescaler with enable and sync clear; parameter TICK_DIV).
- Window computation and FSM stay in mole_game_controller.

Test Plan:
Bench parameters: TICK_DIV=4, MOLE_TIME_INIT=10, MOLE_TIME_STEP=3, MOLE_TIME_MIN=4, LIVES_INIT=3, HITS_PER_LEVEL=2.
1. Reset then start -> next cycle playing=1, lives=3, level=0, time_left=10; time_left=9 after 4 cycles.
2. No guesses for 40 cycles -> one mole_timeout pulse, lives=2, time_left=10. Repeat twice more -> game_over=1, lives=0, playing=0.
3. Four guess_correct pulses -> level=1 after the 2nd with time_left=7; level=2 after the 4th with time_left=4. Two more -> level=3, window clamps to 4.
4. guess_correct and guess_wrong in the same cycle, and guess_correct on an expiring tick -> lives unchanged, no mole_timeout, time_left reloaded.
5. pause mid-window at time_left=6, hold 100 cycles, pulse guess_wrong -> time_left stays 6, lives unchanged. pause again -> countdown resumes from 6. pause then start -> IDLE.
6. Assert rst_n=0 asynchronously mid-PLAY -> all outputs 0 immediately. From OVER, start -> PLAY with lives=3, level=0.
